// File: rtl/serial_arith_pkg.sv
// Shared types and helpers for the bit-serial arithmetic blocks.
//   state_t : FSM encoding of the serial subtractor controller
//   cnt_w   : width of a bit counter that must be able to hold WIDTH
package serial_arith_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Counter width: $clog2(WIDTH+1) keeps a 1-bit counter legal for WIDTH=1.
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin (mod 2), with borrow out.
// Ports:
//   a    : minuend bit
//   b    : subtrahend bit
//   bin  : borrow in
//   d    : difference bit
//   bout : borrow out
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  // Borrow when b exceeds a outright, or when a==b and a borrow comes in.
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: diff = a - b - bin, one bit per clock, LSB
// first, through a single full_subtractor cell and a borrow flop.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand handshake (a, b, bin); ready only when idle
//   a, b, bin           : minuend, subtrahend, borrow in
//   out_valid/out_ready : result handshake; valid only in S_DONE
//   diff, bout          : difference and final borrow, stable while out_valid
//   busy                : high whenever an operation is in progress or pending
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             busy
);

  localparam int            CW   = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           next_state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] diff_sh;
  logic [WIDTH-1:0] diff_next;
  logic             borrow;
  logic             fs_d;
  logic             fs_bo;

  full_subtractor u_fs (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .bin  (borrow),
    .d    (fs_d),
    .bout (fs_bo)
  );

  // Result shift register input: new difference bit enters at the MSB so the
  // LSB computed first ends up at bit 0 after WIDTH shifts.
  always_comb begin
    diff_next            = diff_sh >> 1'b1;
    diff_next[WIDTH-1]   = fs_d;
  end

  // Next-state logic for the idle / shift / done controller.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (in_valid) begin
          next_state = S_SHIFT;
        end else begin
          next_state = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (count == LAST) begin
          next_state = S_DONE;
        end else begin
          next_state = S_SHIFT;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          next_state = S_IDLE;
        end else begin
          next_state = S_DONE;
        end
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  // State register plus handshake/status outputs, registered from next_state
  // so they are glitch-free flop outputs that track the state exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= next_state;
      in_ready  <= (next_state == S_IDLE);
      out_valid <= (next_state == S_DONE);
      busy      <= (next_state != S_IDLE);
    end
  end

  // Datapath: operand capture, serial shifting, borrow chain and result hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh    <= '0;
      b_sh    <= '0;
      diff_sh <= '0;
      borrow  <= 1'b0;
      count   <= '0;
      bout    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_sh   <= a;
            b_sh   <= b;
            borrow <= bin;
            count  <= '0;
          end
        end
        S_SHIFT: begin
          a_sh    <= a_sh >> 1'b1;
          b_sh    <= b_sh >> 1'b1;
          diff_sh <= diff_next;
          borrow  <= fs_bo;
          count   <= count + CW'(1);
          if (count == LAST) begin
            bout <= fs_bo;
          end
        end
        default: begin
          // S_DONE: everything holds so diff/bout stay stable.
        end
      endcase
    end
  end

  assign diff = diff_sh;

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  logic       clk;
  logic       rst_n;

  // WIDTH=8 instance
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       bin;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] diff;
  logic       bout;
  logic       busy;

  // WIDTH=1 instance
  logic       in_valid1;
  logic       in_ready1;
  logic [0:0] a1;
  logic [0:0] b1;
  logic       bin1;
  logic       out_valid1;
  logic       out_ready1;
  logic [0:0] diff1;
  logic       bout1;
  logic       busy1;

  int n_cmp;
  int n_err;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin),
    .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bout(bout), .busy(busy)
  );

  serial_subtractor #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .bin(bin1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .diff(diff1), .bout(bout1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: {bout,diff} = a - b - bin taken modulo 2^9.
  function automatic logic [8:0] ref8(input logic [7:0] x, input logic [7:0] y, input logic c);
    return {1'b0, x} - {1'b0, y} - {8'd0, c};
  endfunction

  // Full operation on the WIDTH=8 instance, checking latency and result.
  task automatic do_op8(input logic [7:0] x, input logic [7:0] y, input logic c, input string tag);
    int         lat;
    int         w;
    logic [8:0] exp;
    exp = ref8(x, y, c);
    w = 0;
    while (!in_ready && w < 50) begin
      tick();
      w++;
    end
    if (!in_ready) check({tag, "_ready_timeout"}, 32'(in_ready), 32'd1);
    a = x; b = y; bin = c; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 50) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'd8);
    check({tag, "_result"}, {23'd0, bout, diff}, {23'd0, exp});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_ready_after"}, {30'd0, in_ready, out_valid}, 32'b10);
  endtask

  initial begin
    logic [7:0] hold_diff;
    logic       hold_bout;
    logic [1:0] exp1;
    int         lat;
    n_cmp = 0;
    n_err = 0;
    in_valid = 1'b0; a = 8'd0; b = 8'd0; bin = 1'b0; out_ready = 1'b0;
    in_valid1 = 1'b0; a1 = 1'b0; b1 = 1'b0; bin1 = 1'b0; out_ready1 = 1'b0;
    rst_n = 1'b0;
    #23;
    check("reset_w8", {27'd0, in_ready, out_valid, busy, bout, 1'b0} | {24'd0, diff}, 32'h10);
    check("reset_w1", {28'd0, in_ready1, out_valid1, busy1, bout1} | {31'd0, diff1}, 32'h8);
    rst_n = 1'b1;
    tick();

    // Directed cases
    do_op8(8'd100, 8'd37, 1'b0, "t1_100_37");
    do_op8(8'd5, 8'd9, 1'b0, "t2_5_9");
    do_op8(8'd0, 8'd0, 1'b1, "t3_0_0_1");
    do_op8(8'hFF, 8'hFF, 1'b1, "t3_ff_ff_1");

    // Result held in S_DONE while the sink stalls and the source keeps pushing
    a = 8'd77; b = 8'd12; bin = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      tick();
      lat++;
    end
    check("t4_latency", 32'(lat), 32'd8);
    check("t4_result", {23'd0, bout, diff}, {23'd0, ref8(8'd77, 8'd12, 1'b1)});
    hold_diff = diff;
    hold_bout = bout;
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0] ? 1'b0 : 1'b1;
      a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
      tick();
      check("t4_stall", {22'd0, out_valid, in_ready, bout, diff}, {22'd0, 1'b1, 1'b0, hold_bout, hold_diff});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t4_release", {29'd0, in_ready, out_valid, busy}, 32'b100);
    tick();
    check("t4_no_capture", {29'd0, in_ready, out_valid, busy}, 32'b100);

    // Asynchronous reset in the middle of shifting
    a = 8'd150; b = 8'd3; bin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    check("t5_async_reset", {20'd0, in_ready, out_valid, busy, bout, diff}, {20'd0, 4'b1000, 8'd0});
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("t5_no_result", {30'd0, out_valid, busy}, 32'd0);
    end
    do_op8(8'd200, 8'd1, 1'b1, "t5_after_reset");

    // WIDTH=1 instance: every operand combination
    for (int k = 0; k < 8; k++) begin
      a1 = k[0]; b1 = k[1]; bin1 = k[2];
      exp1 = {1'b0, k[0]} - {1'b0, k[1]} - {1'b0, k[2]};
      in_valid1 = 1'b1;
      tick();
      in_valid1 = 1'b0;
      lat = 0;
      while (!out_valid1 && lat < 10) begin
        tick();
        lat++;
      end
      check("t6_w1_latency", 32'(lat), 32'd1);
      check("t6_w1_result", {30'd0, bout1, diff1}, {30'd0, exp1});
      out_ready1 = 1'b1;
      tick();
      out_ready1 = 1'b0;
      check("t6_w1_ready", {31'd0, in_ready1}, 32'd1);
    end

    // Random back-to-back operations against the arithmetic model
    for (int i = 0; i < 1000; i++) begin
      do_op8(8'($urandom), 8'($urandom), 1'($urandom), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
